unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction requester) and the memory stage (data requester) of the pipelined core.
- Runs a four-state transaction FSM with one transaction outstanding at a time.
- Data has fixed priority over fetch, with a starvation guard for fetch and a response timeout.
- Returns registered read data and a one-cycle ack to whichever requester won; the core stalls the requester's stage until its ack.

Parameters:
- DATA_WIDTH, 32, width of address, read data and write data.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch request waits; the next grant then goes to fetch.
- TIMEOUT, 16, WAIT cycles without mem_ready_i before the transaction is aborted.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- if_req_i  in  1  fetch request; held high until if_ack_o
- if_addr_i  in  DATA_WIDTH  fetch address; stable while if_req_i is high
- if_rdata_o  out  DATA_WIDTH  fetched instruction, registered
- if_ack_o  out  1  one-cycle completion pulse for fetch
- dm_req_i  in  1  data request; held high until dm_ack_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_byte_i  in  1  byte-wide access
- dm_addr_i  in  DATA_WIDTH  data address
- dm_wdata_i  in  DATA_WIDTH  store data
- dm_rdata_o  out  DATA_WIDTH  load data, registered
- dm_ack_o  out  1  one-cycle completion pulse for data
- mem_req_o  out  1  one-cycle issue strobe to memory
- mem_we_o  out  1  latched write enable
- mem_byte_o  out  1  latched byte-op flag
- mem_addr_o  out  DATA_WIDTH  latched address
- mem_wdata_o  out  DATA_WIDTH  latched write data
- mem_rdata_i  in  DATA_WIDTH  memory read data; valid in the mem_ready_i cycle
- mem_ready_i  in  1  memory completion
- grant_o  out  1  owner of the current or most recent transaction; 0 = fetch, 1 = data
- err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE and any in-flight transaction is dropped with no ack.
  - All outputs go to 0, including rdata registers, latched mem_* fields and grant_o.
  - Streak and timeout counters clear to 0.
  - Requesters still holding req are re-serviced normally after reset.
- IDLE:
  - No request pending: stay in IDLE.
  - Winner selection:
    - Only one of dm_req_i / if_req_i high: that requester wins.
    - Both high: data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
  - On selection: latch the winner's addr/we/byte/wdata into mem_* registers (fetch forces we=0, byte=0), set grant_o, go to REQ.
- REQ: mem_req_o = 1 for exactly this cycle; go to WAIT; clear the timeout counter.
- WAIT:
  - mem_ready_i = 1: capture mem_rdata_i (reads only) into the winner's rdata register; go to RESP.
  - Otherwise increment the timeout counter.
  - Counter reaches TIMEOUT-1 with no ready: go to RESP in abort mode; winner's rdata register is set to 0; err_o pulses in the RESP cycle.
- RESP:
  - Winner's ack pulses for one cycle; go to IDLE.
  - A requester that keeps req high after its ack is treated as a new request in IDLE.
- Latency: request seen in IDLE cycle N -> mem_req_o in N+1 -> ack in N+3 when mem_ready_i arrives in the first WAIT cycle.
  - Back-to-back throughput is therefore one transaction per 4 cycles.
- rdata registers hold their value until the next successful or aborted read for that port.
  - Stores do not modify dm_rdata_o.
- mem_* fields stay stable from REQ until the next IDLE selection.
- Streak counter:
  - Increments (saturating at MAX_DATA_STREAK) on a data grant while if_req_i is high.
  - Clears on any fetch grant, and in any IDLE cycle where if_req_i is low.
- mem_ready_i is ignored outside WAIT.
- Requester dropping req before its ack is a protocol violation: the transaction still completes and the ack still pulses.

Test Plan:
- Fetch only: if_req_i=1, addr 0x10, mem_ready_i in first WAIT cycle with rdata 0x00A00093 -> mem_req_o in cycle 1 with mem_addr_o=0x10, if_ack_o in cycle 3, if_rdata_o=0x00A00093, grant_o=0.
- Simultaneous requests: dm store 0x55 to 0x20 (byte=1) and fetch at 0x14 -> data served first with mem_we_o=1, mem_byte_o=1, mem_wdata_o=0x55, dm_ack_o at cycle 3; fetch issued next, if_ack_o at cycle 7; dm_rdata_o unchanged.
- Starvation guard, MAX_DATA_STREAK=2: dm_req_i and if_req_i held high continuously -> grant order data, data, fetch, data, data, fetch.
- Timeout, TIMEOUT=16: mem_ready_i held 0 on a load -> RESP entered after 16 WAIT cycles, dm_ack_o and err_o pulse together, dm_rdata_o=0, FSM returns to IDLE.
- Reset mid-WAIT: assert rst during WAIT of a fetch -> outputs 0 immediately without a clock edge, no if_ack_o; after release with if_req_i still high, the fetch reissues and completes normally.
- Late ready: mem_ready_i asserted on the 5th WAIT cycle -> ack exactly 1 cycle later, no err_o; a spurious mem_ready_i in IDLE has no effect.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter for a single-port unified memory
module unified_mem_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_ack_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic                  dm_byte_i,
    input  logic [DATA_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  dm_ack_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i,
    output logic                  grant_o,
    output logic                  err_o
);
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam int TCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [TCNT_W-1:0]   TCNT_LAST  = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic [TCNT_W-1:0]   tcnt;
    logic                fetch_starved;

    // A waiting fetch that has watched MAX_DATA_STREAK data grants takes the next slot
    assign fetch_starved = if_req_i && (streak == STREAK_MAX);

    // Transaction FSM: arbitration, memory issue, completion and abort, all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            streak      <= '0;
            tcnt        <= '0;
            grant_o     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_byte_o  <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            if_ack_o    <= 1'b0;
            dm_ack_o    <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            mem_req_o <= 1'b0;
            if_ack_o  <= 1'b0;
            dm_ack_o  <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dm_req_i && !fetch_starved) begin
                        grant_o     <= 1'b1;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_byte_o  <= dm_byte_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                        state       <= S_REQ;
                        // data cannot win here with streak at its cap while fetch waits
                        if (if_req_i) begin
                            streak <= streak + STREAK_W'(1);
                        end else begin
                            streak <= '0;
                        end
                    end else if (if_req_i) begin
                        grant_o     <= 1'b0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_byte_o  <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                        state       <= S_REQ;
                        streak      <= '0;
                    end else begin
                        streak <= '0;
                    end
                end
                S_REQ: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready_i) begin
                        if (!mem_we_o) begin
                            if (grant_o) dm_rdata_o <= mem_rdata_i;
                            else         if_rdata_o <= mem_rdata_i;
                        end
                        if (grant_o) dm_ack_o <= 1'b1;
                        else         if_ack_o <= 1'b1;
                        state <= S_RESP;
                    end else if (tcnt == TCNT_LAST) begin
                        // abort: a read that never completed returns zero
                        if (!mem_we_o) begin
                            if (grant_o) dm_rdata_o <= '0;
                            else         if_rdata_o <= '0;
                        end
                        if (grant_o) dm_ack_o <= 1'b1;
                        else         if_ack_o <= 1'b1;
                        err_o <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_we, dm_byte;
    logic [DW-1:0] if_addr, dm_addr, dm_wdata;
    logic [DW-1:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic          if_ack_o, dm_ack_o, mem_req_o, mem_we_o, mem_byte_o, grant_o, err_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_ready_i;

    logic          ready_r;
    logic [DW-1:0] mem_rdata_r;
    logic          force_ready;
    logic [DW-1:0] spur_data;
    int            wait_n;
    logic [DW-1:0] mrdata;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          is_data;
        logic          we;
        logic          byt;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mrdata;
        int            wait_n;
        logic [DW-1:0] exp_if;
        logic [DW-1:0] exp_dm;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    typedef struct {
        logic [DW-1:0] addr;
        logic          we;
        logic          byt;
        logic [DW-1:0] wdata;
        logic          grant;
    } issue_t;

    typedef struct {
        logic          is_data;
        logic [DW-1:0] exp_if;
        logic [DW-1:0] exp_dm;
        logic          exp_err;
    } resp_t;

    issue_t issue_q[$];
    resp_t  resp_q[$];
    vec_t   vecs[10];

    assign mem_ready_i = ready_r | force_ready;
    assign mem_rdata_i = force_ready ? spur_data : mem_rdata_r;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .DATA_WIDTH     (DW),
        .MAX_DATA_STREAK(2),
        .TIMEOUT        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_rdata_o (if_rdata_o),
        .if_ack_o   (if_ack_o),
        .dm_req_i   (dm_req),
        .dm_we_i    (dm_we),
        .dm_byte_i  (dm_byte),
        .dm_addr_i  (dm_addr),
        .dm_wdata_i (dm_wdata),
        .dm_rdata_o (dm_rdata_o),
        .dm_ack_o   (dm_ack_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_byte_o (mem_byte_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i),
        .grant_o    (grant_o),
        .err_o      (err_o)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_data, input logic we, input logic byt,
                                input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                                input logic [DW-1:0] mrd, input int wn,
                                input logic [DW-1:0] eif, input logic [DW-1:0] edm,
                                input logic eerr, input int elat);
        vec_t v;
        v.is_data = is_data; v.we = we; v.byt = byt; v.addr = addr; v.wdata = wdata;
        v.mrdata = mrd; v.wait_n = wn; v.exp_if = eif; v.exp_dm = edm;
        v.exp_err = eerr; v.exp_lat = elat;
        return v;
    endfunction

    task automatic push_issue(input logic [DW-1:0] addr, input logic we, input logic byt,
                              input logic [DW-1:0] wdata, input logic grant);
        issue_t e;
        e.addr = addr; e.we = we; e.byt = byt; e.wdata = wdata; e.grant = grant;
        issue_q.push_back(e);
    endtask

    task automatic push_resp(input logic is_data, input logic [DW-1:0] eif,
                             input logic [DW-1:0] edm, input logic eerr);
        resp_t r;
        r.is_data = is_data; r.exp_if = eif; r.exp_dm = edm; r.exp_err = eerr;
        resp_q.push_back(r);
    endtask

    // Memory model: raise ready in WAIT cycle wait_n after each issue (0 = never answer)
    initial begin
        int n;
        ready_r     = 1'b0;
        mem_rdata_r = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o === 1'b1 && wait_n > 0) begin
                n = wait_n;
                repeat (n) @(negedge clk);
                ready_r     = 1'b1;
                mem_rdata_r = mrdata;
                @(negedge clk);
                ready_r     = 1'b0;
                mem_rdata_r = 32'hFFFF_FFFF;
            end
        end
    end

    // Scoreboard: compare each issue and each completion with the next expectation
    always @(negedge clk) begin : monitor
        issue_t ie;
        resp_t  re;
        if (rst === 1'b0) begin
            if (mem_req_o) begin
                if (issue_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_issue: addr %h, no issue expected", mem_addr_o);
                end else begin
                    ie = issue_q.pop_front();
                    check("issue_addr", mem_addr_o, ie.addr);
                    check("issue_we", 32'(mem_we_o), 32'(ie.we));
                    check("issue_byte", 32'(mem_byte_o), 32'(ie.byt));
                    check("issue_wdata", mem_wdata_o, ie.wdata);
                    check("issue_grant", 32'(grant_o), 32'(ie.grant));
                end
            end
            if (if_ack_o && dm_ack_o) begin
                tests++; fails++;
                $display("FAIL both_acks: if_ack %b dm_ack %b, required one", if_ack_o, dm_ack_o);
            end else if (if_ack_o || dm_ack_o) begin
                if (resp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ack: if_ack %b dm_ack %b, none expected", if_ack_o, dm_ack_o);
                end else begin
                    re = resp_q.pop_front();
                    check("ack_port", 32'(dm_ack_o), 32'(re.is_data));
                    check("ack_grant", 32'(grant_o), 32'(re.is_data));
                    check("ack_if_rdata", if_rdata_o, re.exp_if);
                    check("ack_dm_rdata", dm_rdata_o, re.exp_dm);
                    check("ack_err", 32'(err_o), 32'(re.exp_err));
                end
            end else if (err_o) begin
                tests++; fails++;
                $display("FAIL err_without_ack: err_o %b, required 0", err_o);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int lat;
        bit got;
        @(negedge clk);
        wait_n = v.wait_n;
        mrdata = v.mrdata;
        if (v.is_data) push_issue(v.addr, v.we, v.byt, v.wdata, 1'b1);
        else           push_issue(v.addr, 1'b0, 1'b0, '0, 1'b0);
        push_resp(v.is_data, v.exp_if, v.exp_dm, v.exp_err);
        if (v.is_data) begin
            dm_req = 1'b1; dm_we = v.we; dm_byte = v.byt; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (if_ack_o || dm_ack_o) got = 1'b1;
        end
        check("ack_latency", 32'(lat), 32'(v.exp_lat));
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dm_cyc, if_cyc, acks, lat;
        bit got;
        logic [DW-1:0] m;
        rst = 1'b1;
        if_req = 0; dm_req = 0; dm_we = 0; dm_byte = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        force_ready = 1'b0; spur_data = '0; wait_n = 0; mrdata = '0;

        //           data we byt addr      wdata         mrdata        wait exp_if        exp_dm        err lat
        vecs[0] = mk(0, 0, 0, 32'h10, 32'h0,        32'h00A00093, 1, 32'h00A00093, 32'h0,        0, 3);
        vecs[1] = mk(1, 0, 0, 32'h40, 32'h0,        32'hDEADBEEF, 1, 32'h00A00093, 32'hDEADBEEF, 0, 3);
        vecs[2] = mk(1, 1, 0, 32'h44, 32'h12345678, 32'hFFFFFFFF, 1, 32'h00A00093, 32'hDEADBEEF, 0, 3);
        vecs[3] = mk(1, 0, 1, 32'h48, 32'h0,        32'h000000AB, 5, 32'h00A00093, 32'h000000AB, 0, 7);
        vecs[4] = mk(1, 0, 0, 32'h4C, 32'h0,        32'h00000099, 0, 32'h00A00093, 32'h0,        1, 18);
        vecs[5] = mk(0, 0, 0, 32'h14, 32'h0,        32'h11223344, 2, 32'h11223344, 32'h0,        0, 4);
        vecs[6] = mk(1, 1, 1, 32'h50, 32'hA5,       32'h0,        0, 32'h11223344, 32'h0,        1, 18);
        vecs[7] = mk(0, 0, 0, 32'h18, 32'h0,        32'h0,        0, 32'h0,        32'h0,        1, 18);
        vecs[8] = mk(1, 0, 0, 32'h60, 32'h0,        32'h0BADF00D, 1, 32'h0,        32'h0BADF00D, 0, 3);
        vecs[9] = mk(0, 0, 0, 32'h90, 32'h0,        32'h00000013, 1, 32'h00000013, 32'h0,        0, 3);

        repeat (3) @(negedge clk);
        check("rst_ctrl", 32'({mem_req_o, mem_we_o, mem_byte_o, grant_o, err_o, if_ack_o, dm_ack_o}), 32'h0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, 32'h0);
        check("rst_if_rdata", if_rdata_o, 32'h0);
        check("rst_dm_rdata", dm_rdata_o, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // simultaneous store and fetch: data first, fetch four cycles later
        @(negedge clk);
        wait_n = 1;
        mrdata = 32'hCAFEF00D;
        push_issue(32'h20, 1'b1, 1'b1, 32'h55, 1'b1);
        push_issue(32'h14, 1'b0, 1'b0, 32'h0, 1'b0);
        push_resp(1'b1, 32'h0, 32'h0BADF00D, 1'b0);
        push_resp(1'b0, 32'hCAFEF00D, 32'h0BADF00D, 1'b0);
        dm_req = 1; dm_we = 1; dm_byte = 1; dm_addr = 32'h20; dm_wdata = 32'h55;
        if_req = 1; if_addr = 32'h14;
        dm_cyc = -1;
        if_cyc = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (dm_ack_o) begin dm_cyc = k; dm_req = 0; end
            if (if_ack_o) begin if_cyc = k; if_req = 0; end
        end
        check("simul_dm_ack_cycle", 32'(dm_cyc), 32'd3);
        check("simul_if_ack_cycle", 32'(if_cyc), 32'd7);

        // starvation guard with a cap of two: data, data, fetch, data, data, fetch
        @(negedge clk);
        m = 32'h5A5A1234;
        wait_n = 1;
        mrdata = m;
        for (int k = 0; k < 6; k++) begin
            if (k % 3 == 2) begin
                push_issue(32'h74, 1'b0, 1'b0, 32'h0, 1'b0);
                push_resp(1'b0, m, m, 1'b0);
            end else begin
                push_issue(32'h70, 1'b0, 1'b0, 32'h0, 1'b1);
                push_resp(1'b1, (k < 2) ? 32'hCAFEF00D : m, m, 1'b0);
            end
        end
        dm_req = 1; dm_we = 0; dm_byte = 0; dm_addr = 32'h70; dm_wdata = 32'h0;
        if_req = 1; if_addr = 32'h74;
        acks = 0;
        for (int k = 0; k < 40 && acks < 6; k++) begin
            @(negedge clk);
            if (if_ack_o || dm_ack_o) acks++;
        end
        dm_req = 0;
        if_req = 0;
        check("streak_ack_count", 32'(acks), 32'd6);

        // reset during WAIT of a fetch, then the held fetch is serviced again
        @(negedge clk);
        wait_n = 0;
        push_issue(32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        if_req = 1; if_addr = 32'h80;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ctrl", 32'({mem_req_o, mem_we_o, mem_byte_o, grant_o, err_o, if_ack_o, dm_ack_o}), 32'h0);
        check("midrst_mem_addr", mem_addr_o, 32'h0);
        check("midrst_if_rdata", if_rdata_o, 32'h0);
        check("midrst_dm_rdata", dm_rdata_o, 32'h0);
        @(negedge clk);
        check("midrst_no_ack", 32'(if_ack_o), 32'h0);
        wait_n = 1;
        mrdata = 32'h600DCAFE;
        push_issue(32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        push_resp(1'b0, 32'h600DCAFE, 32'h0, 1'b0);
        rst = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (if_ack_o) got = 1'b1;
        end
        if_req = 0;
        check("reissue_latency", 32'(lat), 32'd3);

        // spurious ready while idle must not disturb anything
        @(negedge clk);
        spur_data = 32'h0BAD0BAD;
        force_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("spur_quiet", 32'({mem_req_o, if_ack_o, dm_ack_o, err_o}), 32'h0);
        end
        force_ready = 1'b0;
        check("spur_if_rdata", if_rdata_o, 32'h600DCAFE);
        check("spur_dm_rdata", dm_rdata_o, 32'h0);
        run_vec(vecs[9]);

        repeat (2) @(negedge clk);
        check("issue_q_drained", 32'(issue_q.size()), 32'h0);
        check("resp_q_drained", 32'(resp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
